// File: rtl/tt_um_jleugeri_ttt_input_injector.sv
// rtl/tt_um_jleugeri_ttt_input_injector.sv - host-side frame FIFO and external-input token transmitter
module tt_um_jleugeri_ttt_input_injector #(
  parameter int NUM_PROCESSORS  = 16,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int FIFO_DEPTH      = 8,
  localparam int AW  = $clog2(NUM_PROCESSORS),
  localparam int FPW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clock_fast,
  input  logic                       reset,
  input  logic [2:0]                 stage,
  input  logic                       frame_wait,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic [AW-1:0]              host_addr,
  input  logic [NEW_TOKENS_BITS-1:0] host_good,
  input  logic [NEW_TOKENS_BITS-1:0] host_bad,
  input  logic                       host_last,
  output logic                       has_ext_input,
  output logic [AW-1:0]              ext_tgt_addr,
  output logic [NEW_TOKENS_BITS-1:0] new_ext_good_tokens,
  output logic [NEW_TOKENS_BITS-1:0] new_ext_bad_tokens,
  output logic                       hold_i,
  output logic [FPW-1:0]             frames_pending,
  output logic                       overflow,
  output logic                       addr_error
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NTB = NEW_TOKENS_BITS;
  localparam int EW  = AW + 2 * NTB + 1;
  localparam logic [2:0]     STAGE_INPUT = 3'd1;
  localparam logic [FPW-1:0] FP_ONE      = FPW'(1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_DRAIN      = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Entry layout, MSB first: addr | good | bad | last
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          full, empty, full_nxt;
  logic          push, pop;
  logic          addr_bad;
  logic [EW-1:0] push_entry, head;
  logic [AW-1:0] head_addr;
  logic [NTB-1:0] head_good, head_bad;
  logic          head_last;
  logic          in_input;
  logic          set_overflow;

  // FIFO status, push/pop qualification and head field extraction
  always_comb begin
    full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    empty     = (wr_ptr == rd_ptr);
    in_input  = (stage == STAGE_INPUT);
    push      = host_valid && !full;
    pop       = (state == S_DRAIN) && in_input && !empty;
    addr_bad  = ({1'b0, host_addr} >= (AW + 1)'(NUM_PROCESSORS));
    // Bad addresses become harmless zero-token events that still carry the frame boundary
    push_entry = addr_bad ? {{(EW - 1){1'b0}}, host_last}
                          : {host_addr, host_good, host_bad, host_last};
    head      = mem[rd_ptr[PW-1:0]];
    head_addr = head[EW-1 -: AW];
    head_good = head[2*NTB -: NTB];
    head_bad  = head[NTB -: NTB];
    head_last = head[0];
    wr_nxt    = wr_ptr + (PW + 1)'(push);
    rd_nxt    = rd_ptr + (PW + 1)'(pop);
    full_nxt  = (wr_nxt[PW] != rd_nxt[PW]) && (wr_nxt[PW-1:0] == rd_nxt[PW-1:0]);
  end

  // Next-state logic; leaving INPUT aborts any activity but keeps unsent entries queued
  always_comb begin
    state_nxt    = state;
    set_overflow = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_input) begin
          if (frames_pending != '0)  state_nxt = S_DRAIN;
          else if (frame_wait)       state_nxt = S_WAIT_FRAME;
          else                       state_nxt = S_DONE;
        end
      end
      S_WAIT_FRAME: begin
        if (!in_input) begin
          state_nxt = S_IDLE;
        end else if (frames_pending != '0) begin
          state_nxt = S_DRAIN;
        end else if (full) begin
          // A frame larger than the FIFO can never complete: send what is buffered
          state_nxt    = S_DRAIN;
          set_overflow = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!in_input)      state_nxt = S_IDLE;
        else if (empty)     state_nxt = S_DONE;
        else if (head_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!in_input) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock_fast) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clock_fast) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_entry;
  end

  // FIFO pointers and frame counter
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frames_pending <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if ((push && host_last) && !(pop && head_last))
        frames_pending <= frames_pending + FP_ONE;
      else if (!(push && host_last) && (pop && head_last))
        frames_pending <= frames_pending - FP_ONE;
    end
  end

  // Registered outputs; hold_i stays up through the cycle that shows the final event
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      host_ready          <= 1'b1;
      has_ext_input       <= 1'b0;
      ext_tgt_addr        <= '0;
      new_ext_good_tokens <= '0;
      new_ext_bad_tokens  <= '0;
      hold_i              <= 1'b0;
      overflow            <= 1'b0;
      addr_error          <= 1'b0;
    end else begin
      host_ready          <= !full_nxt;
      has_ext_input       <= pop;
      ext_tgt_addr        <= pop ? head_addr : '0;
      new_ext_good_tokens <= pop ? head_good : '0;
      new_ext_bad_tokens  <= pop ? head_bad  : '0;
      hold_i              <= (state_nxt == S_WAIT_FRAME) || (state_nxt == S_DRAIN) || pop;
      if (set_overflow)        overflow   <= 1'b1;
      if (push && addr_bad)    addr_error <= 1'b1;
    end
  end

endmodule
